// File: rtl/trig_sched_pkg.sv
// Shared types and default parameters for the trigger-register command scheduler.
package trig_sched_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned DefNreq     = 8;
   localparam int unsigned DefIdxWidth = 3;
   localparam int unsigned DefToWidth  = 10;
   localparam int unsigned DefTimeout  = 1000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first eligible index strictly after last, wrapping.
module rr_pick #(
   parameter int unsigned NREQ     = 8,
   parameter int unsigned IDXWIDTH = 3
) (
   input  logic [NREQ-1:0]     eligible_i,
   input  logic [IDXWIDTH-1:0] last_i,
   output logic                found_o,
   output logic [IDXWIDTH-1:0] idx_o
);

   int unsigned         cand;
   logic [IDXWIDTH-1:0] cand_idx;

   // Scan from the farthest candidate back so the nearest eligible one is written last.
   always_comb begin
      found_o  = 1'b0;
      idx_o    = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = NREQ; k >= 1; k--) begin
         cand     = (32'(last_i) + k) % NREQ;
         cand_idx = IDXWIDTH'(cand);
         if (eligible_i[cand_idx]) begin
            found_o = 1'b1;
            idx_o   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/trig_sched.sv
// Round-robin scheduler sharing one command engine among trigger-register command bits.
// Optional timeout/fail logic is built when TRIG_SCHED_TIMEOUT_EN is defined.
module trig_sched
   import trig_sched_pkg::*;
#(
   parameter int unsigned NREQ     = DefNreq,
   parameter int unsigned IDXWIDTH = DefIdxWidth,
   parameter int unsigned TOWIDTH  = DefToWidth,
   parameter int unsigned TIMEOUT  = DefTimeout
) (
   input  logic                clk,
   input  logic                reset_l,
   input  logic [NREQ-1:0]     req,
   output logic [NREQ-1:0]     ack,
   output logic [NREQ-1:0]     fail,
   input  logic [NREQ-1:0]     fail_clr,
   output logic                eng_start,
   output logic                eng_abort,
   output logic [IDXWIDTH-1:0] eng_sel,
   input  logic                eng_done,
   output logic                busy
);

   localparam logic [TOWIDTH-1:0] TimeoutCnt = TOWIDTH'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [IDXWIDTH-1:0] last_q, last_d;
   logic [IDXWIDTH-1:0] sel_q, sel_d;
   logic [NREQ-1:0]     armed_q, armed_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic [NREQ-1:0]     fail_set;
   logic                start_q, start_d;
   logic                abort_q, abort_d;
   logic                aborted_q, aborted_d;
   logic                timeout;
   logic                soft_stop;
   logic                done_ok;

   logic [NREQ-1:0]     eligible;
   logic                pick_found;
   logic [IDXWIDTH-1:0] pick_idx;

   // Armed masks the stale high level left while the register clears a bit after ack.
   assign eligible = req & armed_q;

   rr_pick #(
      .NREQ     (NREQ),
      .IDXWIDTH (IDXWIDTH)
   ) u_rr_pick (
      .eligible_i (eligible),
      .last_i     (last_q),
      .found_o    (pick_found),
      .idx_o      (pick_idx)
   );

   // Engine done is not trusted in the start cycle.
   assign done_ok   = eng_done & ~start_q;
   assign soft_stop = ~req[sel_q] & ~aborted_q;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      sel_d     = sel_q;
      armed_d   = armed_q | ~req;
      ack_d     = '0;
      fail_set  = '0;
      start_d   = 1'b0;
      abort_d   = 1'b0;
      aborted_d = aborted_q;

      case (state_q)
         StIdle: begin
            if (pick_found) begin
               sel_d             = pick_idx;
               last_d            = pick_idx;
               armed_d[pick_idx] = 1'b0;
               start_d           = 1'b1;
               aborted_d         = 1'b0;
               state_d           = StRun;
            end
         end
         StRun: begin
            if (soft_stop) begin
               abort_d   = 1'b1;
               aborted_d = 1'b1;
            end
            if (done_ok) begin
               state_d = StDone;
               if (!(aborted_q || soft_stop)) begin
                  ack_d[sel_q] = 1'b1;
               end
            end else if (timeout) begin
               state_d         = StDone;
               abort_d         = 1'b1;
               fail_set[sel_q] = 1'b1;
               if (!(aborted_q || soft_stop)) begin
                  ack_d[sel_q] = 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q   <= StIdle;
         last_q    <= IDXWIDTH'(NREQ - 1);
         sel_q     <= '0;
         armed_q   <= '1;
         ack_q     <= '0;
         start_q   <= 1'b0;
         abort_q   <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         sel_q     <= sel_d;
         armed_q   <= armed_d;
         ack_q     <= ack_d;
         start_q   <= start_d;
         abort_q   <= abort_d;
         aborted_q <= aborted_d;
      end
   end

`ifdef TRIG_SCHED_TIMEOUT_EN
   logic [TOWIDTH-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0]    fail_q, fail_d;

   // Fires in the RUN cycle where the counter would reach TIMEOUT.
   assign timeout = (cnt_q == TimeoutCnt);

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle) begin
         cnt_d = '0;
      end else if (state_q == StRun) begin
         cnt_d = cnt_q + 1'b1;
      end
      // A new set beats a simultaneous clear.
      fail_d = (fail_q & ~fail_clr) | fail_set;
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         cnt_q  <= '0;
         fail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         fail_q <= fail_d;
      end
   end

   assign fail = fail_q;
`else
   logic unused_cfg;

   assign timeout    = 1'b0;
   assign fail       = '0;
   assign unused_cfg = ^{fail_clr, fail_set, TimeoutCnt};
`endif

   assign ack       = ack_q;
   assign eng_start = start_q;
   assign eng_abort = abort_q;
   assign eng_sel   = sel_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_trig_sched.sv
// Directed self-checking bench for trig_sched; timeout cases run when TRIG_SCHED_TIMEOUT_EN is set.
module tb_trig_sched;

   logic       clk;
   logic       reset_l;
   logic [7:0] req;
   logic [7:0] ack;
   logic [7:0] fail;
   logic [7:0] fail_clr;
   logic       eng_start;
   logic       eng_abort;
   logic [2:0] eng_sel;
   logic       eng_done;
   logic       busy;

   int n_checks;
   int n_errors;

   trig_sched #(
      .NREQ     (8),
      .IDXWIDTH (3),
      .TOWIDTH  (10),
      .TIMEOUT  (16)
   ) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .req       (req),
      .ack       (ack),
      .fail      (fail),
      .fail_clr  (fail_clr),
      .eng_start (eng_start),
      .eng_abort (eng_abort),
      .eng_sel   (eng_sel),
      .eng_done  (eng_done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset_l  = 1'b0;
      req      = '0;
      eng_done = 1'b0;
      fail_clr = '0;
      repeat (2) tick();
      reset_l = 1'b1;
      tick();
   endtask

   int         exp_g[4];
   logic [7:0] bit_m;

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_g    = '{0, 7, 0, 7};
      reset_l  = 1'b0;
      req      = '0;
      eng_done = 1'b0;
      fail_clr = '0;
      repeat (3) tick();
      check("rst_ack", ack, 0);
      check("rst_fail", fail, 0);
      check("rst_start", eng_start, 0);
      check("rst_abort", eng_abort, 0);
      check("rst_sel", eng_sel, 0);
      check("rst_busy", busy, 0);
      reset_l = 1'b1;
      tick();

      // Single request, engine done sampled 5 cycles after start.
      req = 8'h04;
      tick();
      check("single_start", eng_start, 1);
      check("single_sel", eng_sel, 2);
      check("single_busy", busy, 1);
      repeat (5) begin
         tick();
         check("single_nostart", eng_start, 0);
         check("single_noack", ack, 0);
      end
      eng_done = 1'b1;
      tick();
      check("single_ack", ack, 8'h04);
      check("single_done_busy", busy, 1);
      eng_done = 1'b0;
      tick();
      check("single_idle", busy, 0);
      check("single_ack_pulse", ack, 0);
      repeat (3) begin
         tick();
         check("single_no_regrant", eng_start, 0);
      end
      req = 8'h00;
      tick();
      req = 8'h04;
      tick();
      check("rearm_start", eng_start, 1);
      check("rearm_sel", eng_sel, 2);
      // Done raised in the start cycle is ignored.
      eng_done = 1'b1;
      tick();
      check("early_done_busy", busy, 1);
      check("early_done_noack", ack, 0);
      tick();
      check("early_done_ack", ack, 8'h04);
      eng_done = 1'b0;
      req      = 8'h00;
      tick();
      check("early_done_idle", busy, 0);

      // Round-robin: index 0 first after reset, then alternate with 7.
      reset_dut();
      req = 8'h81;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_start", eng_start, 1);
         check("rr_sel", eng_sel, exp_g[i]);
         req = 8'h81;
         tick();
         eng_done = 1'b1;
         tick();
         bit_m = 8'h01 << exp_g[i];
         check("rr_ack", ack, bit_m);
         eng_done = 1'b0;
         tick();
         check("rr_idle", busy, 0);
         req = 8'h81 & ~bit_m;
      end
      req = 8'h00;
      repeat (2) tick();

      // Software stop: one abort pulse, DONE without ack.
      req = 8'h08;
      tick();
      check("stop_start", eng_start, 1);
      check("stop_sel", eng_sel, 3);
      repeat (2) tick();
      req = 8'h00;
      tick();
      check("stop_abort", eng_abort, 1);
      req = 8'h08;
      tick();
      check("stop_abort_once", eng_abort, 0);
      req = 8'h00;
      tick();
      check("stop_abort_again", eng_abort, 0);
      check("stop_still_run", busy, 1);
      eng_done = 1'b1;
      tick();
      check("stop_done_busy", busy, 1);
      check("stop_noack", ack, 0);
      check("stop_nofail", fail, 0);
      eng_done = 1'b0;
      tick();
      check("stop_idle", busy, 0);

`ifdef TRIG_SCHED_TIMEOUT_EN
      // Timeout fires in RUN cycle 16; abort/fail/ack show in the DONE cycle after it.
      req = 8'h20;
      tick();
      check("to_start", eng_start, 1);
      check("to_sel", eng_sel, 5);
      repeat (15) begin
         tick();
         check("to_no_early_abort", eng_abort, 0);
      end
      tick();
      check("to_abort", eng_abort, 1);
      check("to_fail", fail, 8'h20);
      check("to_ack", ack, 8'h20);
      req = 8'h00;
      tick();
      check("to_fail_sticky", fail, 8'h20);
      check("to_idle", busy, 0);
      fail_clr = 8'h20;
      tick();
      check("to_fail_clr", fail, 0);
      fail_clr = 8'h00;

      // Clear on the same edge as the set: set wins.
      req = 8'h20;
      tick();
      repeat (15) tick();
      fail_clr = 8'h20;
      tick();
      check("clr_collide_fail", fail, 8'h20);
      check("clr_collide_ack", ack, 8'h20);
      fail_clr = 8'h00;
      req      = 8'h00;
      tick();
      fail_clr = 8'h20;
      tick();
      check("clr_after_collide", fail, 0);
      fail_clr = 8'h00;

      // Done on the timeout cycle: done wins.
      req = 8'h02;
      tick();
      check("done_to_sel", eng_sel, 1);
      repeat (15) tick();
      eng_done = 1'b1;
      tick();
      check("done_to_ack", ack, 8'h02);
      check("done_to_nofail", fail, 0);
      check("done_to_noabort", eng_abort, 0);
      eng_done = 1'b0;
      req      = 8'h00;
      tick();
      check("done_to_idle", busy, 0);
`else
      // Without the timeout option RUN waits indefinitely and fail stays low.
      req = 8'h02;
      tick();
      check("nto_sel", eng_sel, 1);
      fail_clr = 8'hff;
      repeat (20) tick();
      check("nto_busy", busy, 1);
      check("nto_fail", fail, 0);
      check("nto_abort", eng_abort, 0);
      fail_clr = 8'h00;
      eng_done = 1'b1;
      tick();
      check("nto_ack", ack, 8'h02);
      eng_done = 1'b0;
      req      = 8'h00;
      tick();
`endif

      // Reset during RUN clears outputs without waiting for a clock edge.
      req = 8'h10;
      tick();
      check("rrun_start", eng_start, 1);
      check("rrun_sel", eng_sel, 4);
      repeat (2) tick();
      #2;
      reset_l = 1'b0;
      #1;
      check("rrun_busy", busy, 0);
      check("rrun_sel0", eng_sel, 0);
      check("rrun_abort", eng_abort, 0);
      check("rrun_ack", ack, 0);
      check("rrun_fail", fail, 0);
      req      = 8'h11;
      eng_done = 1'b0;
      repeat (2) tick();
      reset_l = 1'b1;
      tick();
      check("rrun_first_start", eng_start, 1);
      check("rrun_first_sel", eng_sel, 0);
      tick();
      eng_done = 1'b1;
      tick();
      check("rrun_first_ack", ack, 8'h01);
      eng_done = 1'b0;
      req      = 8'h00;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
